// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: start bit, DBIT data bits LSB first, stop phase of SB_TICK ticks.
// rx_done_tick is registered, so it rises in the same cycle that dout and frame_err update.
//
// state | meaning
// IDLE  | line idle; waiting for rx_s low
// START | counting to mid start bit; confirm or reject as a glitch
// DATA  | sampling DBIT data bits at mid bit
// STOP  | waiting out the stop phase; sample stop level and publish the word
module uart_rx_os #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [3:0] N_LAST = 4'(DBIT - 1);
    localparam logic [4:0] S_LAST = 5'(SB_TICK - 1);

    state_t          state_q, state_d;
    logic [4:0]      s_q, s_d;
    logic [3:0]      n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            ferr_q, ferr_d;
    logic            done_q, done_d;
    logic            sync1_q, sync2_q;
    logic            rx_s;

    assign rx_s = sync2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            dout_q  <= '0;
            ferr_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            dout_q  <= dout_d;
            ferr_q  <= ferr_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        dout_d  = dout_q;
        ferr_d  = ferr_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == 5'd7) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            // start bit vanished by mid bit: treat as noise
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == 5'd15) begin
                        s_d = '0;
                        b_d = {rx_s, b_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + 4'd1;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        state_d = IDLE;
                        dout_d  = b_q;
                        ferr_d  = ~rx_s;
                        done_d  = 1'b1;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dout         = dout_q;
    assign frame_err    = ferr_q;
    assign rx_done_tick = done_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: an 8-bit/1-stop instance and a 7-bit/2-stop instance.
// Drivers push expected words; monitors pop and compare on each rx_done_tick.
module tb_uart_rx_os;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx, rx2;
    logic       s_tick;
    logic [7:0] dout;
    logic [6:0] dout2;
    logic       done, done2, ferr, ferr2;

    typedef struct {
        logic [8:0] d;
        logic       fe;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int fall1 = -100;
    int fall2 = -100;
    int tk1 = 0;
    int tk2 = 0;

    // ticks that elapse in START/DATA/STOP before the completing tick
    localparam int LAT = 151;

    uart_rx_os #(.DBIT(8), .SB_TICK(16)) dut8 (
        .clk(clk), .reset(reset), .rx(rx), .s_tick(s_tick),
        .dout(dout), .rx_done_tick(done), .frame_err(ferr)
    );

    uart_rx_os #(.DBIT(7), .SB_TICK(32)) dut7 (
        .clk(clk), .reset(reset), .rx(rx2), .s_tick(s_tick),
        .dout(dout2), .rx_done_tick(done2), .frame_err(ferr2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // s_tick high for one clk in every four
    initial begin
        s_tick = 1'b0;
        forever begin
            @(negedge clk);
            s_tick = (cyc % 4 == 0);
        end
    end

    // START is entered on the third edge after rx falls; ticks count from the next edge
    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            if (cyc < fall1 + 4) tk1 = 0;
            else if (s_tick) tk1 = tk1 + 1;
            if (cyc < fall2 + 4) tk2 = 0;
            else if (s_tick) tk2 = tk2 + 1;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (q1.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL dut8 unexpected strobe: dout=%0h expected no strobe", dout);
                end else begin
                    e = q1.pop_front();
                    check("dut8 dout", int'(dout), int'(e.d));
                    check("dut8 frame_err", int'(ferr), int'(e.fe));
                    check("dut8 latency", tk1 - 1, LAT);
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done2) begin
                if (q2.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL dut7 unexpected strobe: dout=%0h expected no strobe", dout2);
                end else begin
                    e = q2.pop_front();
                    check("dut7 dout", int'(dout2), int'(e.d));
                    check("dut7 frame_err", int'(ferr2), int'(e.fe));
                    check("dut7 latency", tk2 - 1, LAT);
                end
            end
        end
    end

    task automatic wait_ticks(input int n);
        repeat (n * 4) @(negedge clk);
    endtask

    task automatic set_rx(input bit which, input logic v);
        if (which) rx2 = v;
        else rx = v;
    endtask

    // called at a negedge; returns at a negedge
    task automatic send(input bit which, input logic [8:0] data, input int nbits,
                        input logic stop_v, input int stop_ticks, input int idle_ticks,
                        input logic fe_exp);
        exp_t e;
        e.d  = data;
        e.fe = fe_exp;
        if (which) q2.push_back(e);
        else q1.push_back(e);
        set_rx(which, 1'b0);
        if (which) fall2 = cyc;
        else fall1 = cyc;
        wait_ticks(16);
        for (int i = 0; i < nbits; i++) begin
            set_rx(which, data[i]);
            wait_ticks(16);
        end
        set_rx(which, stop_v);
        wait_ticks(stop_ticks);
        set_rx(which, 1'b1);
        wait_ticks(idle_ticks);
    endtask

    initial begin
        rx    = 1'b1;
        rx2   = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset dout8", int'(dout), 0);
        check("reset ferr8", int'(ferr), 0);
        check("reset done8", int'(done), 0);
        check("reset dout7", int'(dout2), 0);
        check("reset ferr7", int'(ferr2), 0);
        check("reset done7", int'(done2), 0);
        wait_ticks(4);

        send(1'b0, 9'h0A5, 8, 1'b1, 16, 8, 1'b0);

        // start-bit glitch: low for 5 ticks only
        rx = 1'b0;
        wait_ticks(5);
        rx = 1'b1;
        wait_ticks(12);
        check("glitch dout hold", int'(dout), 'hA5);
        check("glitch ferr hold", int'(ferr), 0);

        // stop low; line stays low past mid stop, so a rejected START follows
        send(1'b0, 9'h03C, 8, 1'b0, 10, 20, 1'b1);
        check("ferr hold dout", int'(dout), 'h3C);
        check("ferr hold flag", int'(ferr), 1);
        send(1'b0, 9'h081, 8, 1'b1, 16, 8, 1'b0);

        send(1'b0, 9'h000, 8, 1'b1, 16, 0, 1'b0);
        send(1'b0, 9'h0FF, 8, 1'b1, 16, 0, 1'b0);
        send(1'b0, 9'h055, 8, 1'b1, 16, 8, 1'b0);

        // reset pulse in the middle of the 4th data bit of an all-ones frame
        rx    = 1'b0;
        fall1 = cyc;
        wait_ticks(16);
        rx = 1'b1;
        wait_ticks(48 + 8);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset dout", int'(dout), 0);
        check("midreset ferr", int'(ferr), 0);
        check("midreset done", int'(done), 0);
        wait_ticks(40);
        send(1'b0, 9'h096, 8, 1'b1, 16, 8, 1'b0);

        send(1'b1, 9'h05A, 7, 1'b1, 32, 8, 1'b0);
        wait_ticks(20);

        check("dut8 frames outstanding", q1.size(), 0);
        check("dut7 frames outstanding", q2.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
